// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package riscv_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        RELEASE,
        DONE,
        ERR
    } boot_state_e;

    localparam int WORD_BYTES    = 4;
    localparam int IDX_W         = $clog2(WORD_BYTES);
    localparam int RELEASE_CNT_W = 8;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs an LSB-first byte stream into 32-bit words; a last byte closes the
// word early with the unfilled upper bytes left at zero.
module boot_byte_packer
    import riscv_boot_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             accept,
    input  logic [7:0]       data,
    input  logic             last,
    output logic             word_ready,
    output logic [31:0]      word,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] idx_q;
    logic [31:0]      pack_q;
    logic [31:0]      merged;
    logic             complete;

    // pack_q is cleared after every word, so the bytes above idx are already zero
    always_comb begin
        merged              = pack_q;
        merged[8*idx_q +: 8] = data;
    end

    assign complete = accept && ((idx_q == IDX_W'(WORD_BYTES - 1)) || last);
    assign idx      = idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            pack_q     <= '0;
            word_ready <= 1'b0;
            word       <= '0;
        end else begin
            word_ready <= complete;
            if (complete)
                word <= merged;
            if (clr) begin
                idx_q  <= '0;
                pack_q <= '0;
            end else if (accept) begin
                if (complete) begin
                    idx_q  <= '0;
                    pack_q <= '0;
                end else begin
                    idx_q  <= idx_q + 1'b1;
                    pack_q <= merged;
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: writes packed words into IMEM and holds the core
// in reset until the load completes. BOOT_CHECKSUM_EN enables the word checksum.
module imem_boot_loader
    import riscv_boot_pkg::*;
#(
    parameter int IMEM_DEPTH  = 256,
    parameter int ADDR_W      = $clog2(IMEM_DEPTH),
    parameter int RELEASE_DLY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W:0]          DEPTH_W  = (ADDR_W + 1)'(IMEM_DEPTH);
    localparam logic [RELEASE_CNT_W-1:0] DLY_LOAD = RELEASE_CNT_W'(RELEASE_DLY - 1);

    boot_state_e              state, state_nxt;
    logic [RELEASE_CNT_W-1:0] rel_cnt;
    logic [ADDR_W-1:0]        waddr_q;
    logic [IDX_W-1:0]         idx;
    logic                     hold_q;
    logic                     accept, overflow, take, rearm, word_done, idx_full;

    assign s_ready   = (state == LOAD);
    assign accept    = s_valid && s_ready;
    assign overflow  = accept && (word_count == DEPTH_W);
    assign take      = accept && !overflow;
    assign idx_full  = (idx == IDX_W'(WORD_BYTES - 1));
    assign word_done = take && (idx_full || s_last);
    assign rearm     = start && (state inside {IDLE, DONE, ERR});

    boot_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (rearm),
        .accept     (take),
        .data       (s_data),
        .last       (s_last),
        .word_ready (imem_we),
        .word       (imem_wdata),
        .idx        (idx)
    );

    assign imem_waddr = waddr_q;
    assign load_done  = (state == DONE);
    assign load_err   = (state == ERR);
    // Re-arm raises the hold immediately so the core never runs a half-loaded image
    assign core_hold  = hold_q || rearm;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = LOAD;
            LOAD: begin
                if (overflow)
                    state_nxt = ERR;
                else if (take && s_last)
                    state_nxt = idx_full ? RELEASE : FLUSH;
            end
            FLUSH:   state_nxt = RELEASE;
            RELEASE: if (rel_cnt == '0) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rel_cnt    <= '0;
            hold_q     <= 1'b1;
            word_count <= '0;
            waddr_q    <= '0;
        end else begin
            state  <= state_nxt;
            hold_q <= (state_nxt != DONE);
            if (state_nxt == RELEASE && state != RELEASE)
                rel_cnt <= DLY_LOAD;
            else if (state == RELEASE && rel_cnt != '0)
                rel_cnt <= rel_cnt - 1'b1;
            if (rearm) begin
                word_count <= '0;
            end else if (word_done) begin
                waddr_q    <= word_count[ADDR_W-1:0];
                word_count <= word_count + 1'b1;
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum_q <= '0;
        else if (rearm)
            sum_q <= '0;
        else if (imem_we)
            sum_q <= sum_q + imem_wdata;
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: cycle table for prog1 plus hand sequences.
module tb_imem_boot_loader;

    localparam int DEPTH  = 4;
    localparam int AW     = 2;
    localparam int DLY    = 4;
    localparam int NROWS  = 17;

    logic          clk, rst, start, s_valid, s_ready, s_last;
    logic [7:0]    s_data;
    logic          imem_we, core_hold, load_done, load_err;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata, checksum;
    logic [AW:0]   word_count;

    imem_boot_loader #(.IMEM_DEPTH(DEPTH), .RELEASE_DLY(DLY)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .core_hold(core_hold), .load_done(load_done),
        .load_err(load_err), .word_count(word_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [7:0]    data;
        logic          last;
        logic          ready;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          hold;
        logic          done;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    vec_t        tbl [NROWS];
    wr_t         wq[$];
    logic [7:0]  p1 [12] = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01,
                             8'h70, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00};
    logic [31:0] w1 [3]  = '{32'h00500093, 32'h00700113, 32'h002081B3};
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk)
        if (!rst && imem_we) wq.push_back('{a: imem_waddr, d: imem_wdata});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_imem_we"}, 32'(imem_we), 0);
        chk({tag, "_waddr"}, 32'(imem_waddr), 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_core_hold"}, 32'(core_hold), 1);
        chk({tag, "_load_done"}, 32'(load_done), 0);
        chk({tag, "_load_err"}, 32'(load_err), 0);
        chk({tag, "_word_count"}, 32'(word_count), 0);
        chk({tag, "_checksum"}, checksum, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Presents one byte until accepted (bounded); returns at the negedge after acceptance
    task automatic send_byte(input logic [7:0] d, input logic l);
        bit ok = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (s_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("byte_accept", 32'(ok), 1);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 60 && !load_done; n++) @(negedge clk);
        chk("done_wait", 32'(load_done), 1);
    endtask

    task automatic chk_prog1(input string tag);
        logic [31:0] sum = 0;
        chk({tag, "_nwrites"}, 32'(wq.size()), 3);
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            chk({tag, "_addr"}, 32'(wq[i].a), 32'(i));
            chk({tag, "_data"}, wq[i].d, w1[i]);
        end
        for (int i = 0; i < 3; i++) sum += w1[i];
        chk({tag, "_word_count"}, 32'(word_count), 3);
`ifdef BOOT_CHECKSUM_EN
        chk({tag, "_checksum"}, checksum, sum);
`else
        chk({tag, "_checksum"}, checksum, 0);
`endif
    endtask

    initial begin
        clk = 0; rst = 1; start = 0; s_valid = 0; s_data = 0; s_last = 0;

        // prog1 back-to-back: row k is the k-th cycle in LOAD
        for (int k = 0; k < NROWS; k++) begin
            tbl[k].valid = (k < 12);
            tbl[k].data  = (k < 12) ? p1[k] : 8'h00;
            tbl[k].last  = (k == 11);
            tbl[k].ready = (k < 12);
            tbl[k].we    = (k == 4 || k == 8 || k == 12);
            tbl[k].addr  = tbl[k].we ? AW'(k / 4 - 1) : '0;
            tbl[k].wdata = tbl[k].we ? w1[k / 4 - 1] : 32'h0;
            tbl[k].hold  = (k < 16);
            tbl[k].done  = (k == 16);
        end

        repeat (2) @(negedge clk);
        #1 chk_reset("rst");
        @(negedge clk) rst = 0;

        pulse_start();
        wq.delete();
        for (int k = 0; k < NROWS; k++) begin
            s_valid = tbl[k].valid; s_data = tbl[k].data; s_last = tbl[k].last;
            #1;
            chk($sformatf("tbl%0d_ready", k), 32'(s_ready), 32'(tbl[k].ready));
            chk($sformatf("tbl%0d_we", k), 32'(imem_we), 32'(tbl[k].we));
            if (tbl[k].we) begin
                chk($sformatf("tbl%0d_addr", k), 32'(imem_waddr), 32'(tbl[k].addr));
                chk($sformatf("tbl%0d_wdata", k), imem_wdata, tbl[k].wdata);
            end
            chk($sformatf("tbl%0d_hold", k), 32'(core_hold), 32'(tbl[k].hold));
            chk($sformatf("tbl%0d_done", k), 32'(load_done), 32'(tbl[k].done));
            @(negedge clk);
        end
        s_valid = 0; s_last = 0;
        chk_prog1("prog1");

        // re-arm from DONE: hold rises combinationally with start
        start = 1'b1;
        #1 chk("rearm_hold", 32'(core_hold), 1);
        chk("rearm_done_before", 32'(load_done), 1);
        @(negedge clk) start = 1'b0;
        #1 chk("rearm_done_after", 32'(load_done), 0);
        chk("rearm_ready", 32'(s_ready), 1);
        chk("rearm_wc", 32'(word_count), 0);

        // partial word goes through FLUSH
        wq.delete();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        #1 chk("flush_ready", 32'(s_ready), 0);
        chk("flush_we", 32'(imem_we), 1);
        wait_done();
        chk("part_nwrites", 32'(wq.size()), 1);
        if (wq.size() > 0) begin
            chk("part_addr", 32'(wq[0].a), 0);
            chk("part_data", wq[0].d, 32'h0000BBAA);
        end
        chk("part_wc", 32'(word_count), 1);

        // backpressure: idle cycle between every byte
        pulse_start();
        wq.delete();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            send_byte(p1[k], k == 11);
        end
        wait_done();
        chk_prog1("gaps");

        // overflow at IMEM_DEPTH words
        pulse_start();
        wq.delete();
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        send_byte(8'd16, 1'b0);
        #1 chk("ovf_err", 32'(load_err), 1);
        chk("ovf_ready", 32'(s_ready), 0);
        chk("ovf_hold", 32'(core_hold), 1);
        chk("ovf_wc", 32'(word_count), 4);
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        chk("ovf_nwrites", 32'(wq.size()), 4);
        for (int k = 0; k < 4 && k < wq.size(); k++) begin
            chk("ovf_addr", 32'(wq[k].a), 32'(k));
            chk("ovf_data", wq[k].d, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        end
        pulse_start();
        #1 chk("ovf_rearm_ready", 32'(s_ready), 1);
        chk("ovf_rearm_err", 32'(load_err), 0);

        // reset after 6 bytes, then a clean reload
        for (int k = 0; k < 6; k++) send_byte(p1[k], 1'b0);
        rst = 1'b1;
        #1 chk_reset("midrst");
        @(negedge clk) rst = 1'b0;
        pulse_start();
        wq.delete();
        for (int k = 0; k < 12; k++) send_byte(p1[k], k == 11);
        wait_done();
        chk_prog1("reload");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
